// File: rtl/ps2_keys_pkg.sv
// Shared scan codes, decoder states, held-key indices and action bit indices
// for the PS/2 action mapper.
package ps2_keys_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_e;

  localparam int NUM_KEYS  = 10;
  localparam int KEY_W     = 0;
  localparam int KEY_A     = 1;
  localparam int KEY_S     = 2;
  localparam int KEY_D     = 3;
  localparam int KEY_SPACE = 4;
  localparam int KEY_ENTER = 5;
  localparam int KEY_UP    = 6;
  localparam int KEY_DOWN  = 7;
  localparam int KEY_LEFT  = 8;
  localparam int KEY_RIGHT = 9;

  localparam int ACT_LEFT  = 0;
  localparam int ACT_RIGHT = 1;
  localparam int ACT_BACK  = 2;
  localparam int ACT_FWD   = 3;
  localparam int ACT_SHOOT = 4;
  localparam int ACT_W     = 5;

  // One-hot held-register mask for a plain code; zero when the code is unknown.
  function automatic logic [NUM_KEYS-1:0] plain_mask(input logic [7:0] code);
    logic [NUM_KEYS-1:0] m;
    m = '0;
    case (code)
      SC_W:     m[KEY_W]     = 1'b1;
      SC_A:     m[KEY_A]     = 1'b1;
      SC_S:     m[KEY_S]     = 1'b1;
      SC_D:     m[KEY_D]     = 1'b1;
      SC_SPACE: m[KEY_SPACE] = 1'b1;
      SC_ENTER: m[KEY_ENTER] = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [NUM_KEYS-1:0] ext_mask(input logic [7:0] code);
    logic [NUM_KEYS-1:0] m;
    m = '0;
    case (code)
      SC_UP:    m[KEY_UP]    = 1'b1;
      SC_DOWN:  m[KEY_DOWN]  = 1'b1;
      SC_LEFT:  m[KEY_LEFT]  = 1'b1;
      SC_RIGHT: m[KEY_RIGHT] = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/fire_pacer.sv
// Rate-limits one player's shoot key into single-cycle pulses.
// Build option: PS2_MAPPER_AUTOFIRE_EN repeats pulses while the key stays held.
module fire_pacer #(
  parameter int FIRE_COOLDOWN = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_held,
  output logic shoot
);

  localparam int CW = (FIRE_COOLDOWN > 2) ? $clog2(FIRE_COOLDOWN) : 1;

`ifdef PS2_MAPPER_AUTOFIRE_EN
  localparam logic AUTOFIRE = 1'b1;
`else
  localparam logic AUTOFIRE = 1'b0;
`endif

  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          shoot_q;
  logic          fire;

  // Reloading with COOLDOWN-1 puts the next eligible pulse exactly COOLDOWN edges later.
  always_comb begin
    fire    = key_held && (cnt_q == '0) && (armed_q || AUTOFIRE);
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (fire) begin
      cnt_d   = CW'(FIRE_COOLDOWN - 1);
      armed_d = 1'b0;
    end else begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      if (!key_held)   armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      armed_q <= 1'b1;
      shoot_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      shoot_q <= fire;
    end
  end

  assign shoot = shoot_q;

endmodule

// File: rtl/ps2_action_mapper.sv
// PS/2 set-2 scan-code decoder producing registered per-player ship actions.
// Build option: PS2_MAPPER_AUTOFIRE_EN (consumed by fire_pacer).
module ps2_action_mapper
  import ps2_keys_pkg::*;
#(
  parameter int NUM_PLAYERS   = 1,
  parameter int FIRE_COOLDOWN = 25_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  input  logic                     controller_type,
  output logic [5*NUM_PLAYERS-1:0] actions
);

  dec_state_e          state_q, state_d;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_KEYS-1:0] pmask, emask;

  // E0 restarts an extended sequence from any state; everything else ends in IDLE.
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    pmask   = plain_mask(byte_in);
    emask   = ext_mask(byte_in);
    if (byte_valid) begin
      state_d = ST_IDLE;
      if (byte_in == SC_E0) begin
        state_d = ST_EXT;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (byte_in == SC_F0) state_d = ST_BRK;
            else                  held_d  = held_q | pmask;
          end
          ST_EXT: begin
            if (byte_in == SC_F0) state_d = ST_EXT_BRK;
            else                  held_d  = held_q | emask;
          end
          ST_BRK:     held_d = held_q & ~pmask;
          ST_EXT_BRK: held_d = held_q & ~emask;
          default:    state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic       use_wasd;
    logic       kf, kb, kr, kl, ks;
    logic       shoot;
    logic [3:0] mov_q, mov_d;

    // Single-player picks the movement cluster live; two-player splits them.
    assign use_wasd = (NUM_PLAYERS == 1) ? controller_type : (p == 0);
    assign kf = use_wasd ? held_q[KEY_W] : held_q[KEY_UP];
    assign kb = use_wasd ? held_q[KEY_S] : held_q[KEY_DOWN];
    assign kr = use_wasd ? held_q[KEY_D] : held_q[KEY_RIGHT];
    assign kl = use_wasd ? held_q[KEY_A] : held_q[KEY_LEFT];
    assign ks = (p == 0) ? held_q[KEY_SPACE] : held_q[KEY_ENTER];

    always_comb begin
      mov_d = '0;
      mov_d[ACT_FWD]   = kf & ~kb;
      mov_d[ACT_BACK]  = kb & ~kf;
      mov_d[ACT_RIGHT] = kr & ~kl;
      mov_d[ACT_LEFT]  = kl & ~kr;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) mov_q <= '0;
      else       mov_q <= mov_d;
    end

    fire_pacer #(
      .FIRE_COOLDOWN(FIRE_COOLDOWN)
    ) u_pacer (
      .clk     (clk),
      .reset   (reset),
      .key_held(ks),
      .shoot   (shoot)
    );

    assign actions[ACT_W*p +: ACT_W] = {shoot, mov_q};
  end

endmodule
